// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings the MMCM out of reset and supervises it.
// It pulses mmcm_rst, waits (with a timeout) for LOCKED, and requires lock to
// hold through a stabilisation window before it raises pll_ready. It retries
// a bounded number of times before it parks in FAULT, and it re-sequences on
// loss of lock. The block runs only on the free-running refclk.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int TIMER_WIDTH         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       restart,
    input  logic       mmcm_locked,
    output logic       mmcm_rst,
    output logic       pll_ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILISE = 3'd2,
        S_READY     = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    // Terminal timer values: each phase ends on the last cycle of its window.
    localparam logic [TIMER_WIDTH-1:0] RST_LAST  = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TO_LAST   = TIMER_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] STB_LAST  = TIMER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);
    localparam logic [3:0]             MAX_R     = 4'(MAX_RETRIES);

    state_t                 cur;
    state_t                 nxt;
    logic [TIMER_WIDTH-1:0] timer;
    logic [3:0]             retry_nxt;
    logic [7:0]             llc_nxt;
    logic                   sync_meta;
    logic                   locked_s;

    // LOCKED is asynchronous to refclk: two-flop synchroniser before any use.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= mmcm_locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state and counter updates; restart pre-empts every other transition.
    always_comb begin
        nxt       = cur;
        retry_nxt = retry_count;
        llc_nxt   = lock_loss_count;
        if (restart) begin
            nxt       = S_RESET;
            retry_nxt = 4'd0;
        end else begin
            case (cur)
                S_RESET: begin
                    if (timer == RST_LAST) nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a timeout that lands on the same cycle.
                    if (locked_s) begin
                        nxt = S_STABILISE;
                    end else if (timer == TO_LAST) begin
                        if (retry_count == MAX_R) begin
                            nxt = S_FAULT;
                        end else begin
                            retry_nxt = retry_count + 4'd1;
                            nxt       = S_RESET;
                        end
                    end
                end
                S_STABILISE: begin
                    // A drop inside the window counts as a failed attempt and
                    // takes precedence over the window expiring.
                    if (!locked_s) begin
                        if (retry_count == MAX_R) begin
                            nxt = S_FAULT;
                        end else begin
                            retry_nxt = retry_count + 4'd1;
                            nxt       = S_RESET;
                        end
                    end else if (timer == STB_LAST) begin
                        nxt       = S_READY;
                        retry_nxt = 4'd0;
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        if (lock_loss_count != 8'hFF) llc_nxt = lock_loss_count + 8'd1;
                        retry_nxt = 4'd0;
                        nxt       = S_RESET;
                    end
                end
                S_FAULT: begin
                    nxt = S_FAULT;
                end
                default: begin
                    nxt = S_RESET;
                end
            endcase
        end
    end

    // State, shared timer, counters and output decodes, all registered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur             <= S_RESET;
            timer           <= '0;
            retry_count     <= 4'd0;
            lock_loss_count <= 8'd0;
            mmcm_rst        <= 1'b1;
            pll_ready       <= 1'b0;
            fault           <= 1'b0;
        end else begin
            cur             <= nxt;
            // restart clears the timer even in RESET so the full pulse reruns.
            timer           <= (restart || nxt != cur) ? '0 : timer + TIMER_ONE;
            retry_count     <= retry_nxt;
            lock_loss_count <= llc_nxt;
            mmcm_rst        <= (nxt == S_RESET) || (nxt == S_FAULT);
            pll_ready       <= (nxt == S_READY);
            fault           <= (nxt == S_FAULT);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer. Each scenario pushes the expected output
// vector {state, mmcm_rst, pll_ready, fault, retry_count, lock_loss_count}
// for the coming edge, then pops it and compares it once the edge has passed.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst;
    logic       restart;
    logic       mmcm_locked;
    logic       mmcm_rst;
    logic       pll_ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    pll_lock_sequencer #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT_CYCLES(32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES(2),
        .TIMER_WIDTH(20)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .restart(restart),
        .mmcm_locked(mmcm_locked),
        .mmcm_rst(mmcm_rst),
        .pll_ready(pll_ready),
        .fault(fault),
        .retry_count(retry_count),
        .lock_loss_count(lock_loss_count),
        .state(state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    logic [17:0] exp_q[$];
    logic [17:0] e;
    logic [17:0] obs;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign obs = {state, mmcm_rst, pll_ready, fault, retry_count, lock_loss_count};

    function automatic logic [17:0] pk(input logic [2:0] s, input logic r, input logic rd,
                                       input logic f, input logic [3:0] rc, input logic [7:0] ll);
        return {s, r, rd, f, rc, ll};
    endfunction

    // Advance one active edge and settle past it.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; restart = 1'b0; mmcm_locked = 1'b0;
        #1;
        exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_clean_start();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(i < 4 ? pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0)
                                  : pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL clean_pulse i=%0d got=%h exp=%h", i, obs, e); end
        end
        mmcm_locked = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 2)      exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
            else if (i < 11) exp_q.push_back(pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
            else             exp_q.push_back(pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL clean_lock i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_loss_in_ready();
        mmcm_locked = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i <= 2)     exp_q.push_back(pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1 - 8'd1));
            else if (i < 7) exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1));
            else            exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL loss_drop i=%0d got=%h exp=%h", i, obs, e); end
        end
        mmcm_locked = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 2)      exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1));
            else if (i < 11) exp_q.push_back(pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1));
            else             exp_q.push_back(pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL loss_relock i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_glitch_stabilise();
        restart = 1'b1;
        exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1));
        step();
        restart = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL glitch_restart got=%h exp=%h", obs, e); end
        // Enter STABILISE, then sit 4 cycles in it (timer reaches 4).
        for (int i = 1; i <= 9; i++) begin
            if (i < 4)       exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1));
            else if (i == 4) exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1));
            else             exp_q.push_back(pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL glitch_enter i=%0d got=%h exp=%h", i, obs, e); end
        end
        for (int i = 1; i <= 3; i++) begin
            mmcm_locked = (i != 1);
            exp_q.push_back(i < 3 ? pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1)
                                  : pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 8'd1));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL glitch_drop i=%0d got=%h exp=%h", i, obs, e); end
        end
        for (int i = 1; i <= 13; i++) begin
            if (i < 4)       exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 8'd1));
            else if (i == 4) exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 8'd1));
            else if (i < 13) exp_q.push_back(pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd1, 8'd1));
            else             exp_q.push_back(pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL glitch_recover i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_repeat_loss();
        for (int k = 2; k <= 3; k++) begin
            mmcm_locked = 1'b0;
            exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'(k)));
            for (int i = 0; i < 3; i++) step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL repeat_loss k=%0d got=%h exp=%h", k, obs, e); end
            mmcm_locked = 1'b1;
            exp_q.push_back(pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'(k)));
            for (int i = 0; i < 40 && !pll_ready; i++) step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL repeat_relock_timeout k=%0d got=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic test_never_locks();
        // restart out of READY with LOCKED gone: lock_loss_count stays at 3.
        restart = 1'b1; mmcm_locked = 1'b0;
        exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd3));
        step();
        restart = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL never_restart got=%h exp=%h", obs, e); end
        for (int p = 0; p < 3; p++) begin
            for (int i = 1; i <= 36; i++) begin
                if (i < 4)       exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'(p), 8'd3));
                else if (i < 36) exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'(p), 8'd3));
                else if (p < 2)  exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'(p + 1), 8'd3));
                else             exp_q.push_back(pk(3'd4, 1'b1, 1'b0, 1'b1, 4'd2, 8'd3));
                step();
                e = exp_q.pop_front(); n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL never_seq p=%0d i=%0d got=%h exp=%h", p, i, obs, e); end
            end
        end
        for (int i = 0; i < 1000; i++) begin
            exp_q.push_back(pk(3'd4, 1'b1, 1'b0, 1'b1, 4'd2, 8'd3));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL fault_hold i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_restart_fault();
        restart = 1'b1;
        exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd3));
        step();
        restart = 1'b0;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL restart_fault got=%h exp=%h", obs, e); end
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(i < 4 ? pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd3)
                                  : pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd3));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL restart_pulse i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_async_reset();
        mmcm_locked = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(i < 3 ? pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd3)
                                  : pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd3));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL async_enter i=%0d got=%h exp=%h", i, obs, e); end
        end
        #3 rst = 1'b1;
        exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL async_assert got=%h exp=%h", obs, e); end
        #2 rst = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            if (i < 4)       exp_q.push_back(pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
            else if (i == 4) exp_q.push_back(pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
            else if (i < 13) exp_q.push_back(pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
            else             exp_q.push_back(pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0));
            step();
            e = exp_q.pop_front(); n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL async_resequence i=%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_start();
        test_loss_in_ready();
        test_glitch_stabilise();
        test_repeat_loss();
        test_never_locks();
        test_restart_fault();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Controls power-up and recovery of the clock-generation MMCM (pll_base). It drives the MMCM reset for a fixed minimum pulse and waits for LOCKED with a timeout. Lock must then hold for a stabilisation window before pll_ready is raised. The block retries a bounded number of times before declaring a fault, and it re-sequences automatically on loss of lock. It runs on the free-running board reference clock, never on an MMCM output, and its outputs feed the per-domain reset generators.

Parameters:
RESET_CYCLES, 16, refclk cycles mmcm_rst is held high per reset pulse (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry (>=1)
STABLE_CYCLES, 1024, cycles mmcm_locked must stay high before pll_ready (>=1)
MAX_RETRIES, 3, re-reset attempts after the initial pulse before FAULT (0..15)
TIMER_WIDTH, 20, width of the shared timer; every *_CYCLES value must be < 2^TIMER_WIDTH

Ports:
refclk  input  1  free-running reference clock; sole clock of the block
rst  input  1  asynchronous, active-high reset
restart  input  1  synchronous single-cycle request to re-sequence from scratch
mmcm_locked  input  1  MMCM LOCKED, asynchronous to refclk
mmcm_rst  output  1  MMCM RST drive
pll_ready  output  1  MMCM locked and stable
fault  output  1  lock acquisition failed; sticky until restart/rst
retry_count  output  4  retries consumed in the current acquisition
lock_loss_count  output  8  saturating count of lock losses seen in READY
state  output  3  encoded FSM state for debug: RESET=0, WAIT_LOCK=1, STABILISE=2, READY=3, FAULT=4

Behaviour:
- Clocking and reset: one clock, refclk. rst is asynchronous and active-high. All flops reset asynchronously.
- On rst, without waiting for a clock edge:
  - state=RESET, timer=0, retry_count=0, lock_loss_count=0, sync flops=0.
  - mmcm_rst=1, pll_ready=0, fault=0.
- Synchroniser: mmcm_locked passes through a 2-flop synchroniser to give locked_s. Latency is 2 edges. The FSM uses only locked_s.
- Output decode (all are registered state decodes; no combinational path from inputs):
  - mmcm_rst=1 iff state is RESET or FAULT.
  - pll_ready=1 iff state is READY.
  - fault=1 iff state is FAULT.
- Timer: clears on every state change and increments each cycle otherwise.
- RESET: stays exactly RESET_CYCLES cycles. On timer==RESET_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1: go to STABILISE.
  - Otherwise, on timer==LOCK_TIMEOUT_CYCLES-1: if retry_count==MAX_RETRIES go to FAULT; else retry_count+1 and go to RESET.
- STABILISE:
  - locked_s=0 on any cycle: treated as a retry, with the same budget rule as a timeout (FAULT if exhausted, else retry_count+1 and go to RESET).
  - On timer==STABLE_CYCLES-1 with locked_s=1: go to READY and clear retry_count.
- READY: on locked_s=0, lock_loss_count increments (saturating at 255), retry_count=0, go to RESET.
- FAULT: absorbing state. mmcm_rst stays high. Exits only via restart or rst.
- restart:
  - Highest priority; overrides every other transition in every state.
  - Next state is RESET, timer=0, retry_count=0.
  - lock_loss_count is preserved.
  - restart while already in RESET restarts the full RESET_CYCLES pulse.
- Simultaneous events:
  - Timeout and locked_s rising on the same cycle in WAIT_LOCK: lock wins, go to STABILISE.
  - Expiry and locked_s falling on the same cycle in STABILISE: the fall wins, go to RESET.
- Reset mid-operation: rst in any state immediately gives the reset values above. Sequencing restarts cleanly on release.
- Arithmetic: retry_count compares against MAX_RETRIES in 4 bits. lock_loss_count never wraps.

Test Plan:
Parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean start:
  - Stimulus: release rst; raise mmcm_locked 10 cycles later.
  - Required: mmcm_rst high exactly 4 cycles after release; pll_ready rises exactly 11 edges after mmcm_locked rises (2 sync + 1 transition + 8 stabilise); retry_count=0.
- Never locks:
  - Stimulus: mmcm_locked held 0.
  - Required: three mmcm_rst pulses of 4 cycles each, separated by 32-cycle WAIT_LOCK windows; retry_count steps 1, 2; FAULT reached with fault=1, mmcm_rst=1, state=4; all held for 1000 further cycles.
- Loss in READY:
  - Stimulus: drop mmcm_locked for 20 cycles, then re-raise.
  - Required: pll_ready falls 3 edges after the drop; lock_loss_count=1; one 4-cycle mmcm_rst pulse; pll_ready returns after relock timing as in the clean start.
- Glitch in STABILISE:
  - Stimulus: mmcm_locked low for 1 cycle at STABILISE cycle 5.
  - Required: state returns to RESET; retry_count=1; no pll_ready pulse; lock_loss_count unchanged.
- restart from FAULT:
  - Stimulus: from the FAULT of the never-locks scenario with lock_loss_count=3, pulse restart.
  - Required: next edge state=0, fault=0, retry_count=0, lock_loss_count=3; a new 4-cycle reset pulse follows.
- Async reset:
  - Stimulus: assert rst mid-STABILISE, between clock edges.
  - Required: mmcm_rst=1 and state=0 before the next refclk edge; both counters 0.
